// File: rtl/boot_uart_pkg.sv
`timescale 1ns/1ps
// Shared FSM state type, oversampling constants and defaults for the boot UART receiver.
package boot_uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  localparam int OVS            = 16;
  localparam int OW             = $clog2(OVS);
  localparam int SAMPLE_TICK_A  = 7;
  localparam int SAMPLE_TICK_B  = 8;
  localparam int SAMPLE_TICK_C  = 9;
  localparam int DEF_FIFO_DEPTH = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/boot_uart_fifo.sv
`timescale 1ns/1ps
// Synchronous byte FIFO with registered valid/full; push seen on valid one cycle later.
// A push while full is accepted only when a pop happens in the same cycle.
module boot_uart_fifo import boot_uart_pkg::*; #(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk_bufg,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       valid,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic        do_push, do_pop;

  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign wr_nxt  = do_push ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_nxt  = do_pop  ? rd_ptr + PTR_ONE : rd_ptr;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      valid  <= (wr_nxt != rd_nxt);
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

  always_ff @(posedge clk_bufg) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
endmodule

// File: rtl/boot_uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver with 16x oversampling, 7/8/9 majority voting and a small output FIFO.
// Byte visible on m_valid two cycles after the stop-bit sample; a full FIFO drops new bytes and sets overrun.
module boot_uart_rx import boot_uart_pkg::*; #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk_bufg,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic       busy
);
  localparam int DIV = CLK_HZ / (BAUD * OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  rx_state_t     state, state_nxt;
  logic          sync_a, sync_b, rx_prev, rx_s, fall;
  logic [CW-1:0] tick_cnt;
  logic [OW-1:0] ovs_cnt;
  logic [2:0]    bit_idx;
  logic          samp_a, samp_b, maj;
  logic [7:0]    shreg;
  logic          tick, at_c, bit_end;
  logic          push_set, ferr_set, push_q;
  logic          fifo_full, ovr_evt;

  assign rx_s    = sync_b;
  assign fall    = rx_prev & ~sync_b;
  assign tick    = (tick_cnt == CW'(DIV - 1));
  assign at_c    = tick && (ovs_cnt == OW'(SAMPLE_TICK_C));
  assign bit_end = tick && (ovs_cnt == OW'(OVS - 1));
  assign maj     = maj3(samp_a, samp_b, rx_s);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk_bufg) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_set  = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      ST_IDLE:  if (fall) state_nxt = ST_START;
      ST_START: begin
        if (at_c && maj)  state_nxt = ST_IDLE;
        else if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = ST_STOP;
      ST_STOP: begin
        if (at_c) begin
          if (maj) begin
            push_set  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: if (bit_end && rx_s) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      sync_a    <= 1'b1;
      sync_b    <= 1'b1;
      rx_prev   <= 1'b1;
      tick_cnt  <= '0;
      ovs_cnt   <= '0;
      bit_idx   <= '0;
      samp_a    <= 1'b0;
      samp_b    <= 1'b0;
      shreg     <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_a    <= rx;
      sync_b    <= sync_a;
      rx_prev   <= sync_b;
      push_q    <= push_set;
      frame_err <= ferr_set;
      if (state == ST_IDLE) begin
        tick_cnt <= '0;
        ovs_cnt  <= '0;
        bit_idx  <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
        if (tick) begin
          // In WAIT_HIGH the oversample counter measures the current run of high ticks.
          if (state == ST_WAIT_HIGH) ovs_cnt <= rx_s ? ovs_cnt + OW'(1) : '0;
          else if (ferr_set)         ovs_cnt <= '0;
          else                       ovs_cnt <= ovs_cnt + OW'(1);
          if (ovs_cnt == OW'(SAMPLE_TICK_A)) samp_a <= rx_s;
          if (ovs_cnt == OW'(SAMPLE_TICK_B)) samp_b <= rx_s;
          if (at_c && state == ST_DATA)      shreg  <= {maj, shreg[7:1]};
          if (bit_end && state == ST_DATA)   bit_idx <= bit_idx + 3'd1;
        end
      end
    end
  end

  boot_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_bufg  (clk_bufg),
    .resetn    (resetn),
    .push      (push_q),
    .push_data (shreg),
    .pop       (m_ready),
    .pop_data  (m_data),
    .valid     (m_valid),
    .full      (fifo_full)
  );

  assign ovr_evt = push_q & fifo_full & ~(m_valid & m_ready);

  always_ff @(posedge clk_bufg) begin
    if (!resetn)      overrun <= 1'b0;
    else if (ovr_evt) overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end
endmodule

// File: tb/tb_boot_uart_rx.sv
`timescale 1ns/1ps
// Drives 8N1 frames on rx and checks delivered bytes and flags against a queue model of the receiver.
module tb_boot_uart_rx;
  localparam int      CLK_HZ  = 18432000;
  localparam int      BAUD    = 115200;
  localparam int      DEPTH   = 4;
  localparam int      DIV     = CLK_HZ / (BAUD * 16);
  localparam realtime HALF_NS = 1.0e9 / CLK_HZ / 2.0;
  localparam realtime BIT_NS  = 1.0e9 / BAUD;

  logic       clk_bufg = 1'b0;
  logic       resetn, rx, m_ready, ovr_clr;
  logic [7:0] m_data;
  logic       m_valid, frame_err, overrun, busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_ferr = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] mq[$];
  logic       ovr_exp = 1'b0;

  boot_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_bufg  (clk_bufg),
    .resetn    (resetn),
    .rx        (rx),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .busy      (busy)
  );

  always #(HALF_NS) clk_bufg = ~clk_bufg;

  always begin
    @(negedge clk_bufg);
    #1;
    if (resetn && m_valid && m_ready) got.push_back(m_data);
    if (frame_err) n_ferr++;
  end

  initial begin
    #(5000000.0);
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_bufg);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = stop_bit;
    #(BIT_NS);
    if (stop_bit) #(BIT_NS);
  endtask

  // Reference: a ready consumer takes every good byte; otherwise bytes queue up to DEPTH, extras are lost.
  task automatic model_push(input logic [7:0] b);
    if (m_ready)                exp_q.push_back(b);
    else if (mq.size() < DEPTH) mq.push_back(b);
    else                        ovr_exp = 1'b1;
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_cnt"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
  endtask

  initial begin
    logic [7:0] b, nb;
    int         w;
    bit         hit;

    resetn = 1'b0; rx = 1'b1; m_ready = 1'b1; ovr_clr = 1'b0;
    cycles(5);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 8'h00);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    cycles(5);

    // Single good byte
    send_frame(8'h23, 1'b1);
    model_push(8'h23);
    cycles(5);
    check_out("b23");
    chk("b23_ferr", n_ferr, 0);
    chk("b23_ovr", overrun, ovr_exp);
    chk("b23_valid", m_valid, 0);

    // False start: short low glitch
    rx = 1'b0;
    #(1000.0);
    @(negedge clk_bufg);
    chk("fs_busy_hi", busy, 1);
    #(1000.0);
    rx = 1'b1;
    #(BIT_NS * 2);
    @(negedge clk_bufg);
    chk("fs_busy_lo", busy, 0);
    check_out("fs");
    chk("fs_ferr", n_ferr, 0);

    // Bad stop bit, line held low then released
    send_frame(8'h07, 1'b0);
    #(BIT_NS);
    @(negedge clk_bufg);
    chk("fe_pulses", n_ferr, 1);
    chk("fe_busy", busy, 1);
    rx = 1'b1;
    w = 0;
    while (busy && w < 40 * DIV) begin
      @(negedge clk_bufg);
      w++;
    end
    chk("fe_drop_not_early", (w >= 15 * DIV), 1);
    chk("fe_drop_not_late", (w <= 16 * DIV + 4), 1);
    chk("fe_valid", m_valid, 0);
    check_out("fe");

    // Random bytes with a ready consumer
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      model_push(b);
    end
    cycles(5);
    check_out("rnd");

    // Fill with no consumer: fifth byte overruns
    m_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1);
      model_push(8'(v));
      @(negedge clk_bufg);
      chk($sformatf("fill_head_%0d", v), m_data, mq[0]);
      chk($sformatf("fill_valid_%0d", v), m_valid, 1);
    end
    chk("fill_ovr", overrun, ovr_exp);
    cycles(1);
    ovr_clr = 1'b1;
    cycles(1);
    ovr_clr = 1'b0;
    ovr_exp = 1'b0;
    chk("ovr_cleared", overrun, ovr_exp);
    check_out("fill");

    // Full FIFO: pop exactly on the push cycle of a new byte
    nb = 8'($urandom_range(0, 255));
    hit = 1'b0;
    fork
      send_frame(nb, 1'b1);
      begin
        int i = 0;
        while (!hit && i < 40 * 16 * DIV) begin
          @(negedge clk_bufg);
          if (dut.push_q) hit = 1'b1;
          i++;
        end
        if (hit) begin
          m_ready = 1'b1;
          @(posedge clk_bufg);
          #1;
          m_ready = 1'b0;
        end
      end
    join
    chk("pp_push_seen", hit, 1);
    exp_q.push_back(mq.pop_front());
    mq.push_back(nb);
    cycles(3);
    chk("pp_ovr", overrun, 0);
    chk("pp_valid", m_valid, 1);
    chk("pp_head", m_data, mq[0]);
    m_ready = 1'b1;
    cycles(DEPTH + 4);
    while (mq.size() > 0) exp_q.push_back(mq.pop_front());
    check_out("pp");
    chk("pp_empty", m_valid, 0);

    // Reset in the middle of a frame with a byte already queued
    m_ready = 1'b0;
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1);
    model_push(b);
    rx = 1'b0;
    #(BIT_NS);
    rx = 1'b1;
    #(BIT_NS);
    rx = 1'b0;
    #(BIT_NS / 2);
    @(negedge clk_bufg);
    chk("mid_busy", busy, 1);
    cycles(1);
    resetn = 1'b0;
    rx = 1'b1;
    mq.delete();
    cycles(3);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 8'h00);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_busy", busy, 0);
    cycles(3);
    resetn = 1'b1;
    cycles(5);
    m_ready = 1'b1;
    cycles(2);
    chk("post_rst_valid", m_valid, 0);
    send_frame(8'h0D, 1'b1);
    model_push(8'h0D);
    cycles(5);
    check_out("rst_0d");
    chk("end_ferr", n_ferr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/boot_uart_rx.md
BOOT_UART_RX -- requirements
Module: boot_uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, 100000000, clk_bufg frequency in Hz.
REQ-002 SHALL have parameter BAUD, 115200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, 4, receive byte FIFO entries (power of two, at least 2).
REQ-004 SHALL have port clk_bufg input 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port resetn input 1, synchronous active-low reset.
REQ-006 SHALL have port rx input 1, asynchronous serial line, idle high.
REQ-007 SHALL have port m_data output 8, byte at FIFO head.
REQ-008 SHALL have port m_valid output 1, FIFO non-empty.
REQ-009 SHALL have port m_ready input 1, consumer pops the head when m_valid and m_ready are both high.
REQ-010 SHALL have port frame_err output 1, one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun output 1, sticky flag set when a received byte is dropped.
REQ-012 SHALL have port ovr_clr input 1, clears overrun.
REQ-013 SHALL have port busy output 1, high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-015 SHALL generate a 16x oversample tick every DIV = CLK_HZ/(BAUD*16) cycles, using integer truncation (54 at the defaults).
REQ-016 SHALL hold the tick counter at 0 in IDLE and restart it at the detected start edge.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-018 IDLE->START SHALL occur on a synchronized high-to-low transition.
REQ-019 In START, the bit SHALL be sampled as the majority of the values at oversample ticks 7, 8 and 9.
REQ-020 A high START sample SHALL be a false start: return to IDLE with no output.
REQ-021 DATA SHALL take 8 bits LSB first, one per 16 ticks, each sampled as a 7/8/9 majority; then go to STOP.
REQ-022 In STOP, a high majority sample SHALL push the byte and return to IDLE.
REQ-023 In STOP, a low majority sample SHALL pulse frame_err for one cycle, discard the byte and go to WAIT_HIGH.
REQ-024 WAIT_HIGH SHALL return to IDLE only after the synchronized rx has been high for 16 consecutive ticks (break handling).
REQ-025 The push SHALL occur on the cycle after the stop-bit sample; m_valid SHALL rise the following cycle (registered flags).
REQ-026 m_data SHALL be stable while m_valid is high and m_ready is low.
REQ-027 A push while full with no pop SHALL drop the new byte, set overrun and leave the FIFO contents unchanged.
REQ-028 A push and pop in the same cycle while full SHALL accept both, leave the count unchanged and not set overrun.
REQ-029 A push and pop in the same cycle while empty SHALL be impossible, since m_valid is low.
REQ-030 m_ready while empty SHALL be ignored.
REQ-031 ovr_clr SHALL clear overrun; when it coincides with a new overrun event, the set SHALL win.
REQ-032 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full/empty SHALL come from the MSB comparison.

Reset
REQ-033 While resetn is low: state=IDLE, counters=0, both synchronizer flops=1, FIFO empty.
REQ-034 While resetn is low: m_valid=0, m_data=0x00, frame_err=0, overrun=0, busy=0.
REQ-035 Reset mid-frame SHALL abandon the partial byte; after release, the first high-to-low edge seen SHALL be treated as a start edge.

Structure
REQ-036 Package boot_uart_pkg SHALL hold the FSM state enum, OVS=16, the SAMPLE_TICKS constants (7, 8, 9) and the default FIFO_DEPTH.
REQ-037 The FIFO SHALL be a sub-module boot_uart_fifo (synchronous, registered flags, data[7:0]); the synchronizer, tick generator and FSM SHALL stay in boot_uart_rx.

Verification
REQ-038 Send 0x23 at 115200 8N1, m_ready=1 -> one m_valid cycle with m_data=0x23; frame_err=0; overrun=0.
REQ-039 Drive rx low for 2 us, then high -> busy pulses, no push, state returns to IDLE.
REQ-040 Send 0x07 with the stop bit forced low, then release high -> frame_err pulses once, FIFO stays empty, busy drops only after 16 high ticks.
REQ-041 Send 0x01..0x05 with m_ready=0 -> FIFO holds 0x01..0x04, overrun=1, 0x05 is absent; ovr_clr -> overrun=0.
REQ-042 With the FIFO full, pop on the exact push cycle -> count stays 4, overrun stays 0, read order 0x02,0x03,0x04,new.
REQ-043 Assert resetn low mid-DATA, release, send 0x0D -> only 0x0D is delivered; all outputs are at reset values during reset.
